// File: rtl/cam_pkg.sv
// Shared constants and types for the OV7670 QQVGA RGB444 capture path.
package cam_pkg;

    // RGB444 pixel layout inside the 12-bit buffer word
    localparam int PX_W  = 12;
    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    // QQVGA geometry; FRAME_PX is also the address of the reserved black pixel
    localparam int H_PX_DEF = 160;
    localparam int V_PX_DEF = 120;
    localparam int FRAME_PX = H_PX_DEF * V_PX_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VS,
        ST_VBLANK,
        ST_BYTE_HI,
        ST_BYTE_LO
    } cam_state_t;

endpackage

// File: rtl/cam_pixel_assembler.sv
// Joins the two camera bytes of an RGB444 pixel into one 12-bit word.
// The first byte's red nibble is held; the second byte is used live so the
// caller can register the full pixel in the same cycle it samples byte two.
module cam_pixel_assembler
    import cam_pkg::*;
#(
    parameter int DW = PX_W
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          latch_hi,
    input  logic          drop,
    input  logic [7:0]    byte_in,
    output logic [DW-1:0] pixel
);

    logic [R_MSB-R_LSB:0] r_q;

    // hold red from the first byte; a dropped half pixel is forgotten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_q <= '0;
        else if (latch_hi)
            r_q <= byte_in[3:0];
        else if (drop)
            r_q <= '0;
    end

    // place R, G, B into their fields
    always_comb begin
        pixel              = '0;
        pixel[R_MSB:R_LSB] = r_q;
        pixel[G_MSB:G_LSB] = byte_in[7:4];
        pixel[B_MSB:B_LSB] = byte_in[3:0];
    end

endmodule

// File: rtl/cam_frame_writer.sv
// Camera write-side front end: turns the OV7670 byte stream into raster-order
// writes of 12-bit pixels into the frame buffer, never touching the black
// pixel at address H_PX*V_PX.
module cam_frame_writer
    import cam_pkg::*;
#(
    parameter int AW   = 15,
    parameter int DW   = 12,
    parameter int H_PX = H_PX_DEF,
    parameter int V_PX = V_PX_DEF
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic [7:0]    cam_data,
    output logic [AW-1:0] px_addr,
    output logic [DW-1:0] px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic          busy,
    output logic          line_err,
    output logic          ovf_err
);

    // line counter saturates one past H_PX so long lines still flag an error
    localparam int            LW        = $clog2(H_PX + 2);
    localparam logic [AW-1:0] FRAME_END = AW'(H_PX * V_PX);
    localparam logic [LW-1:0] LINE_LEN  = LW'(H_PX);
    localparam logic [LW-1:0] LINE_SAT  = LW'(H_PX + 1);

    cam_state_t    state;
    logic [AW-1:0] addr_cnt;
    logic [LW-1:0] line_cnt;
    logic          href_q;
    logic          latch_hi;
    logic          drop;
    logic [DW-1:0] pixel;

    assign latch_hi = (state == ST_BYTE_HI) && !cam_vsync && cam_href;
    assign drop     = (state == ST_BYTE_LO) && !cam_vsync && !cam_href;

    cam_pixel_assembler #(
        .DW (DW)
    ) u_asm (
        .clk      (clk),
        .rst_n    (rst_n),
        .latch_hi (latch_hi),
        .drop     (drop),
        .byte_in  (cam_data),
        .pixel    (pixel)
    );

    // capture FSM with counters, error flags and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            addr_cnt   <= '0;
            line_cnt   <= '0;
            href_q     <= 1'b0;
            px_addr    <= '0;
            px_data    <= '0;
            px_wr      <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
            line_err   <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            px_wr      <= 1'b0;
            frame_done <= 1'b0;
            href_q     <= cam_href;

            case (state)
                ST_IDLE: begin
                    if (init) begin
                        state    <= ST_WAIT_VS;
                        busy     <= 1'b1;
                        line_err <= 1'b0;
                        ovf_err  <= 1'b0;
                    end
                end

                ST_WAIT_VS: begin
                    if (cam_vsync)
                        state <= ST_VBLANK;
                end

                ST_VBLANK: begin
                    addr_cnt <= '0;
                    line_cnt <= '0;
                    if (!init) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (!cam_vsync) begin
                        state <= ST_BYTE_HI;
                    end
                end

                ST_BYTE_HI, ST_BYTE_LO: begin
                    // VSYNC ends the frame from either byte phase
                    if (cam_vsync) begin
                        frame_done <= 1'b1;
                        if (init) begin
                            state <= ST_VBLANK;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (state == ST_BYTE_HI) begin
                        if (cam_href)
                            state <= ST_BYTE_LO;
                    end else if (cam_href) begin
                        state <= ST_BYTE_HI;
                        if (line_cnt != LINE_SAT)
                            line_cnt <= line_cnt + 1'b1;
                        if (addr_cnt == FRAME_END) begin
                            ovf_err <= 1'b1;
                        end else begin
                            px_data  <= pixel;
                            px_addr  <= addr_cnt;
                            px_wr    <= 1'b1;
                            addr_cnt <= addr_cnt + 1'b1;
                        end
                    end else begin
                        state    <= ST_BYTE_HI;
                        line_err <= 1'b1;
                    end

                    // line length check on the HREF falling edge; never
                    // coincides with a completed pixel since that needs HREF high
                    if (href_q && !cam_href) begin
                        if (line_cnt != LINE_LEN)
                            line_err <= 1'b1;
                        line_cnt <= '0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Scoreboard bench for cam_frame_writer: stimulus pushes expected writes,
// a negedge monitor pops and compares every px_wr cycle.
module tb_cam_frame_writer;
    import cam_pkg::*;

    typedef struct packed {
        logic [14:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic [14:0] px_addr;
    logic [11:0] px_data;
    logic        px_wr;
    logic        frame_done;
    logic        busy;
    logic        line_err;
    logic        ovf_err;

    int  checks;
    int  failures;
    int  fd_cnt;
    int  fd_exp;
    int  exp_addr;
    int  gidx;
    bit  expect_en;
    logic [14:0] last_addr;
    wr_t exp_q[$];

    cam_frame_writer #(
        .AW   (15),
        .DW   (12),
        .H_PX (160),
        .V_PX (120)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .px_addr    (px_addr),
        .px_data    (px_data),
        .px_wr      (px_wr),
        .frame_done (frame_done),
        .busy       (busy),
        .line_err   (line_err),
        .ovf_err    (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (frame_done === 1'b1)
            fd_cnt++;
        if (px_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                         px_addr, px_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(px_addr), 32'(e.addr));
                chk("wr_data", 32'(px_data), 32'(e.data));
                last_addr = px_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input bit fixed);
        logic [7:0] g;
        logic [7:0] hi;
        logic [7:0] lo;
        wr_t e;
        g  = gidx[7:0];
        hi = fixed ? 8'h0A : {4'h5, g[3:0]};
        lo = fixed ? 8'hBC : (g ^ 8'h3C);
        gidx++;
        cam_href = 1'b1;
        cam_data = hi;
        tick();
        cam_data = lo;
        if (expect_en && exp_addr < FRAME_PX) begin
            e.addr = 15'(exp_addr);
            e.data = {hi[3:0], lo};
            exp_q.push_back(e);
            exp_addr++;
        end
        tick();
    endtask

    task automatic send_line(input int n, input bit half, input bit fixed);
        for (int i = 0; i < n; i++)
            send_pixel(fixed);
        if (half) begin
            cam_href = 1'b1;
            cam_data = 8'h5F;
            tick();
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        repeat (3) tick();
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        exp_addr  = 0;
        expect_en = 1'b1;
        repeat (2) tick();
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        fd_exp++;
        repeat (4) tick();
    endtask

    initial begin
        checks = 0; failures = 0; fd_cnt = 0; fd_exp = 0;
        exp_addr = 0; gidx = 0; expect_en = 1'b0; last_addr = '0;
        rst_n = 1'b0; init = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
        repeat (3) tick();
        chk("rst_px_wr",   32'(px_wr), 0);
        chk("rst_px_addr", 32'(px_addr), 0);
        chk("rst_px_data", 32'(px_data), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_errs",    32'({line_err, ovf_err, frame_done}), 0);
        rst_n = 1'b1;
        tick();

        // capture enabled mid-frame: nothing written until VSYNC high then low
        init = 1'b1;
        tick();
        chk("busy_after_init", 32'(busy), 1);
        send_line(160, 1'b0, 1'b0);
        send_line(160, 1'b0, 1'b0);
        chk("no_write_midframe", 32'(exp_q.size()), 0);
        frame_start();
        send_line(160, 1'b0, 1'b0);
        send_line(160, 1'b0, 1'b0);
        frame_end();
        chk("fd_first_frame", 32'(fd_cnt), 32'(fd_exp));
        chk("line_err_clean", 32'(line_err), 0);

        // short line: flag after its HREF fall, addresses stay contiguous
        frame_start();
        send_line(160, 1'b0, 1'b0);
        chk("line_err_before_short", 32'(line_err), 0);
        send_line(159, 1'b0, 1'b0);
        chk("line_err_short_line", 32'(line_err), 1);
        send_line(160, 1'b0, 1'b0);
        frame_end();
        chk("fd_short_frame", 32'(fd_cnt), 32'(fd_exp));
        chk("line_err_sticky", 32'(line_err), 1);

        // init dropped mid-frame: frame completes, then IDLE
        frame_start();
        chk("line_err_next_frame", 32'(line_err), 1);
        send_line(160, 1'b0, 1'b0);
        init = 1'b0;
        send_line(160, 1'b0, 1'b0);
        frame_end();
        chk("fd_init_drop", 32'(fd_cnt), 32'(fd_exp));
        chk("busy_idle", 32'(busy), 0);
        init = 1'b1;
        tick();
        chk("line_err_cleared", 32'(line_err), 0);
        chk("busy_reinit", 32'(busy), 1);

        // half pixel at end of a full line: discarded, next pixel contiguous
        frame_start();
        send_line(160, 1'b1, 1'b0);
        chk("line_err_half_px", 32'(line_err), 1);
        send_line(160, 1'b0, 1'b0);
        frame_end();
        chk("fd_half_frame", 32'(fd_cnt), 32'(fd_exp));
        init = 1'b0;
        repeat (2) tick();
        chk("busy_vblank_exit", 32'(busy), 0);
        init = 1'b1;
        tick();
        chk("line_err_cleared2", 32'(line_err), 0);

        // full frame of 0xABC plus an extra line that must saturate
        frame_start();
        for (int l = 0; l < 120; l++)
            send_line(160, 1'b0, 1'b1);
        chk("full_frame_drained", 32'(exp_q.size()), 0);
        chk("full_last_addr", 32'(last_addr), 32'(FRAME_PX - 1));
        chk("ovf_before_extra", 32'(ovf_err), 0);
        chk("line_err_full", 32'(line_err), 0);
        send_line(160, 1'b0, 1'b1);
        chk("ovf_after_extra", 32'(ovf_err), 1);
        chk("last_addr_kept", 32'(last_addr), 32'(FRAME_PX - 1));
        frame_end();
        chk("fd_full_frame", 32'(fd_cnt), 32'(fd_exp));

        // asynchronous reset mid-line after a first byte
        frame_start();
        for (int i = 0; i < 4; i++)
            send_pixel(1'b0);
        cam_href = 1'b1;
        cam_data = 8'h57;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_px_addr", 32'(px_addr), 0);
        chk("mid_rst_px_data", 32'(px_data), 0);
        chk("mid_rst_busy",    32'(busy), 0);
        chk("mid_rst_flags",   32'({px_wr, frame_done, line_err, ovf_err}), 0);
        cam_data = 8'h21;
        repeat (2) tick();
        rst_n = 1'b1;
        expect_en = 1'b0;
        send_line(160, 1'b0, 1'b0);
        chk("busy_after_rst", 32'(busy), 1);
        chk("fd_after_rst", 32'(fd_cnt), 32'(fd_exp));
        chk("queue_empty_end", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_frame_writer.md
Name: cam_frame_writer

Overview:
- Write-side front end of the dual-port frame buffer.
- Samples the OV7670 camera byte stream (QQVGA 160x120, RGB444, two bytes per pixel) on the pixel clock.
- Assembles 12-bit pixels and drives the buffer's write port (address, data, write enable) in raster order from address 0.
- The VGA side reads the same buffer through the read port; buffer address H_PX*V_PX (19200) is reserved as the black pixel and must never be written.

Parameters:
- AW, 15, buffer address width; 2**AW must be greater than H_PX*V_PX.
- DW, 12, pixel width (RGB444); fixed at 12 for this format.
- H_PX, 160, pixels per line.
- V_PX, 120, lines per frame.

Ports:
- clk  input  1  camera pixel clock (PCLK); all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- init  input  1  capture enable (level).
- cam_vsync  input  1  camera VSYNC, high during vertical blanking.
- cam_href  input  1  camera HREF, high while line bytes are valid.
- cam_data  input  8  camera byte bus.
- px_addr  output  AW  buffer write address (to addr_in).
- px_data  output  DW  buffer write data (to data_in).
- px_wr  output  1  buffer write enable (to regwrite), one cycle per pixel.
- frame_done  output  1  one-cycle pulse at end of each captured frame.
- busy  output  1  high in any state other than IDLE.
- line_err  output  1  sticky: a line had a pixel count other than H_PX, or HREF dropped mid-pixel.
- ovf_err  output  1  sticky: a frame delivered more than H_PX*V_PX pixels.

Behaviour:
- Reset (asynchronous, rst_n=0) sets all outputs and internal state to 0 and the FSM to IDLE.
- Camera inputs are sampled directly; they are synchronous to clk.
- IDLE: if init=1, go to WAIT_VS. The sticky errors clear on the IDLE->WAIT_VS transition.
- WAIT_VS: if cam_vsync=1, go to VBLANK. This never starts capture mid-frame.
- VBLANK: pixel address counter := 0 and line pixel counter := 0.
  - If init=0, go to IDLE.
  - Else if cam_vsync=0, go to BYTE_HI.
- BYTE_HI:
  - cam_vsync=1 (frame end): pulse frame_done for one cycle. Go to VBLANK if init=1, else IDLE.
  - Else if cam_href=1: latch cam_data[3:0] as R and go to BYTE_LO.
- BYTE_LO:
  - cam_href=1: register px_data={R, cam_data[7:4] G, cam_data[3:0] B} and px_addr=address counter. Assert px_wr for exactly the next cycle, increment the address and line counters, go to BYTE_HI.
  - cam_href=0 (HREF dropped between bytes): discard the half pixel, set line_err, go to BYTE_HI.
  - cam_vsync=1 takes priority and behaves as in BYTE_HI.
- Latency: px_wr/px_addr/px_data are valid in the cycle after the second byte is sampled. Maximum write rate is 1 pixel per 2 clks.
- Line check: on each HREF falling edge (registered previous href=1, current=0) while capturing:
  - if line counter != H_PX, set line_err;
  - line counter := 0 in both cases.
- Saturation: when the address counter equals H_PX*V_PX, further pixels set ovf_err and px_wr stays 0. The address never reaches or passes 19200, so the black pixel is preserved.
- init dropped mid-frame: the current frame completes (frame_done pulses), then the FSM goes to IDLE.
- frame_done also pulses for short frames (fewer pixels); only the pixels received are written.
- busy=0 only in IDLE.
- px_data and px_addr hold their last value when px_wr=0.
- Reset mid-frame: everything returns to IDLE immediately. The next capture re-synchronises through WAIT_VS, so the first partial frame is never written.

Decomposition:
- Shared package cam_pkg holds:
  - RGB444 field positions;
  - H_PX/V_PX defaults;
  - derived constant FRAME_PX = H_PX*V_PX;
  - FSM state encoding (IDLE, WAIT_VS, VBLANK, BYTE_HI, BYTE_LO).
- One sub-module is natural: cam_pixel_assembler (byte-pair to 12-bit pixel with half-pixel discard). The FSM, counters and error logic stay in the top.

Test Plan:
- Reset then init=1 with vsync low and a full frame already in progress -> no px_wr until a vsync high then low. The first write is px_addr=0.
- Clean 160x120 frame, bytes 0x0A,0xBC per pixel -> 19200 writes, px_data=0xABC, addresses 0..19199 consecutive. frame_done pulses once at vsync rise. line_err=0, ovf_err=0.
- One line with 159 pixels -> line_err=1 after that line's HREF fall. Address continues without a gap (the next line starts at the previous address+1). The flag stays set until re-init.
- HREF falls after the first byte of a pixel -> no write for the half pixel, line_err=1, next full pixel written at the expected address.
- Frame with 121 lines -> writes stop at address 19199, ovf_err=1, address 19200 never written.
- init dropped mid-frame -> frame_done pulses at the next vsync rise, FSM returns to IDLE, busy=0. rst_n asserted mid-line -> all outputs 0 in the same cycle, no further px_wr.
